// File: rtl/level_pkg.sv
// level_pkg: shared types and constants for the level sequencer.
//   state_e      - sequencer FSM states
//   ROOM_*       - 10-bit room select codes driven onto Level_Sel
//   is_timed_state - true for the states that run the frame timer
package level_pkg;

    typedef enum logic [1:0] {
        ST_TITLE      = 2'd0,
        ST_PLAY       = 2'd1,
        ST_TRANSITION = 2'd2,
        ST_GAMEOVER   = 2'd3
    } state_e;

    localparam logic [9:0] ROOM_TITLE  = 10'd0;
    localparam logic [9:0] ROOM_OVER   = 10'd1;
    localparam logic [9:0] ROOM_UNDER  = 10'd2;
    localparam logic [9:0] ROOM_CASTLE = 10'd3;

    // States in which the screen is blanked and the frame timer counts.
    function automatic logic is_timed_state(input state_e s);
        return (s == ST_TRANSITION) || (s == ST_GAMEOVER);
    endfunction

endpackage

// File: rtl/level_sequencer_frame_timer.sv
// frame_timer: 8-bit loadable down-counter clocked by frame ticks.
//   clk, rst_n - clock, async active-low reset (count cleared)
//   load       - load load_val (wins over a tick in the same cycle)
//   load_val   - value to load
//   tick       - decrement enable, one pulse per video frame
//   done       - registered one-cycle pulse after the count reaches zero
module frame_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       tick,
    output logic       done
);

    logic [7:0] count_q;
    logic [7:0] count_d;
    logic       done_q;
    logic       done_d;

    // Next count: load has priority; an idle (zero) counter ignores ticks.
    always_comb begin
        count_d = count_q;
        done_d  = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
            done_d  = (count_q == 8'd1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter and done registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: rtl/level_sequencer.sv
// level_sequencer: room/level flow controller (title, play, transition,
// game over) for a platformer.
//   Clk, Reset_n      - clock, async active-low reset
//   frame_tick        - one pulse per video frame
//   start_btn         - start request (title only)
//   pipe_enter, pipe_exit, flag_reached, mario_dead - gameplay events
//   Level_Sel         - room select code (0 title, 1 overworld, 2 underground, 3 castle)
//   load_pulse        - one-cycle pulse when Level_Sel takes a new value
//   from_pipe         - current room was entered through a pipe
//   transition_active - screen blanking during transition / game over
//   freeze            - physics halt, high outside PLAY
//   lives             - remaining lives
// All outputs come straight from flops.
module level_sequencer
    import level_pkg::*;
#(
    parameter int TRANS_FRAMES    = 60,
    parameter int GAMEOVER_FRAMES = 180,
    parameter int START_LIVES     = 3
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       pipe_enter,
    input  logic       pipe_exit,
    input  logic       flag_reached,
    input  logic       mario_dead,
    output logic [9:0] Level_Sel,
    output logic       load_pulse,
    output logic       from_pipe,
    output logic       transition_active,
    output logic       freeze,
    output logic [2:0] lives
);

    localparam logic [7:0] TRANS_LOAD = 8'(TRANS_FRAMES);
    localparam logic [7:0] OVER_LOAD  = 8'(GAMEOVER_FRAMES);
    localparam logic [2:0] LIVES_INIT = 3'(START_LIVES);

    state_e     state_q, state_d;
    logic [9:0] level_sel_q, level_sel_d;
    logic [9:0] pending_q, pending_d;
    logic       pend_pipe_q, pend_pipe_d;
    logic       from_pipe_q, from_pipe_d;
    logic [2:0] lives_q, lives_d;
    logic       load_pulse_q, load_pulse_d;
    logic       trans_act_q, trans_act_d;
    logic       freeze_q, freeze_d;
    logic       entry_q, entry_d;

    logic       ev_valid_s;
    logic       ev_death_s;
    logic [9:0] ev_room_s;
    logic       ev_pipe_s;
    logic       ev_gameover_s;

    logic       timer_load_s;
    logic [7:0] timer_val_s;
    logic       timer_done_s;

    // Timer is loaded in the first cycle of a timed state, so a tick that
    // coincides with state entry is swallowed by the load.
    assign timer_load_s = entry_q && is_timed_state(state_q);
    assign timer_val_s  = (state_q == ST_GAMEOVER) ? OVER_LOAD : TRANS_LOAD;

    frame_timer u_frame_timer (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .load     (timer_load_s),
        .load_val (timer_val_s),
        .tick     (frame_tick),
        .done     (timer_done_s)
    );

    // Gameplay event decode: events illegal for the current room are dropped
    // first, then the highest-priority remaining event is taken.
    always_comb begin
        ev_valid_s = 1'b0;
        ev_death_s = 1'b0;
        ev_room_s  = ROOM_TITLE;
        ev_pipe_s  = 1'b0;
        if (mario_dead) begin
            ev_valid_s = 1'b1;
            ev_death_s = 1'b1;
            ev_room_s  = ROOM_OVER;
        end else if (flag_reached && (level_sel_q == ROOM_OVER)) begin
            ev_valid_s = 1'b1;
            ev_room_s  = ROOM_CASTLE;
        end else if (flag_reached && (level_sel_q == ROOM_CASTLE)) begin
            ev_valid_s = 1'b1;
            ev_room_s  = ROOM_TITLE;
        end else if (pipe_enter && (level_sel_q == ROOM_OVER)) begin
            ev_valid_s = 1'b1;
            ev_room_s  = ROOM_UNDER;
            ev_pipe_s  = 1'b1;
        end else if (pipe_exit && (level_sel_q == ROOM_UNDER)) begin
            ev_valid_s = 1'b1;
            ev_room_s  = ROOM_OVER;
            ev_pipe_s  = 1'b1;
        end else begin
            ev_valid_s = 1'b0;
        end
    end

    // The last life lost sends the game to the game-over screen.
    assign ev_gameover_s = ev_death_s && (lives_q <= 3'd1);

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_TITLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_TITLE: begin
                if (start_btn) state_d = ST_TRANSITION;
                else           state_d = ST_TITLE;
            end
            ST_PLAY: begin
                if (ev_valid_s) state_d = ev_gameover_s ? ST_GAMEOVER : ST_TRANSITION;
                else            state_d = ST_PLAY;
            end
            ST_TRANSITION: begin
                if (timer_done_s) state_d = (pending_q == ROOM_TITLE) ? ST_TITLE : ST_PLAY;
                else              state_d = ST_TRANSITION;
            end
            ST_GAMEOVER: begin
                if (timer_done_s) state_d = ST_TITLE;
                else              state_d = ST_GAMEOVER;
            end
            default: state_d = ST_TITLE;
        endcase
    end

    // FSM output / datapath next values. Level_Sel and from_pipe only move
    // at timer expiry; the destination waits in pending_q meanwhile.
    always_comb begin
        level_sel_d  = level_sel_q;
        pending_d    = pending_q;
        pend_pipe_d  = pend_pipe_q;
        from_pipe_d  = from_pipe_q;
        lives_d      = lives_q;
        load_pulse_d = 1'b0;
        case (state_q)
            ST_TITLE: begin
                if (start_btn) begin
                    pending_d   = ROOM_OVER;
                    pend_pipe_d = 1'b0;
                end else begin
                    pending_d   = pending_q;
                end
            end
            ST_PLAY: begin
                if (ev_valid_s && ev_death_s) begin
                    if (ev_gameover_s) begin
                        lives_d     = 3'd0;
                        pending_d   = ROOM_TITLE;
                        pend_pipe_d = 1'b0;
                    end else begin
                        lives_d     = lives_q - 3'd1;
                        pending_d   = ROOM_OVER;
                        pend_pipe_d = 1'b0;
                    end
                end else if (ev_valid_s) begin
                    pending_d   = ev_room_s;
                    pend_pipe_d = ev_pipe_s;
                end else begin
                    pending_d   = pending_q;
                end
            end
            ST_TRANSITION: begin
                if (timer_done_s) begin
                    level_sel_d  = pending_q;
                    from_pipe_d  = pend_pipe_q;
                    load_pulse_d = 1'b1;
                    // Winning returns to title with a full set of lives.
                    if (pending_q == ROOM_TITLE) lives_d = LIVES_INIT;
                    else                         lives_d = lives_q;
                end else begin
                    level_sel_d  = level_sel_q;
                end
            end
            ST_GAMEOVER: begin
                if (timer_done_s) begin
                    level_sel_d  = ROOM_TITLE;
                    pending_d    = ROOM_TITLE;
                    pend_pipe_d  = 1'b0;
                    from_pipe_d  = 1'b0;
                    lives_d      = LIVES_INIT;
                    load_pulse_d = 1'b1;
                end else begin
                    level_sel_d  = level_sel_q;
                end
            end
            default: begin
                level_sel_d = ROOM_TITLE;
                pending_d   = ROOM_TITLE;
            end
        endcase
    end

    // Status flags registered from the next state so they line up with state_q.
    always_comb begin
        freeze_d    = (state_d != ST_PLAY);
        trans_act_d = is_timed_state(state_d);
        entry_d     = (state_d != state_q);
    end

    // Datapath and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            level_sel_q  <= ROOM_TITLE;
            pending_q    <= ROOM_TITLE;
            pend_pipe_q  <= 1'b0;
            from_pipe_q  <= 1'b0;
            lives_q      <= LIVES_INIT;
            load_pulse_q <= 1'b0;
            trans_act_q  <= 1'b0;
            freeze_q     <= 1'b1;
            entry_q      <= 1'b0;
        end else begin
            level_sel_q  <= level_sel_d;
            pending_q    <= pending_d;
            pend_pipe_q  <= pend_pipe_d;
            from_pipe_q  <= from_pipe_d;
            lives_q      <= lives_d;
            load_pulse_q <= load_pulse_d;
            trans_act_q  <= trans_act_d;
            freeze_q     <= freeze_d;
            entry_q      <= entry_d;
        end
    end

    assign Level_Sel         = level_sel_q;
    assign load_pulse        = load_pulse_q;
    assign from_pipe         = from_pipe_q;
    assign transition_active = trans_act_q;
    assign freeze            = freeze_q;
    assign lives             = lives_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Testbench for level_sequencer: directed scenarios plus a randomized run
// checked against a room/lives game model kept in the bench.
module tb_level_sequencer;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_tick, start_btn, pipe_enter, pipe_exit, flag_reached, mario_dead;
    logic [9:0] Level_Sel;
    logic       load_pulse, from_pipe, transition_active, freeze;
    logic [2:0] lives;

    int errors    = 0;
    int checks    = 0;
    int pulse_cnt = 0;

    // Game model: current room, lives, and whether we sit on the title screen.
    int m_room  = 0;
    int m_lives = 3;
    bit m_title = 1'b1;

    level_sequencer #(
        .TRANS_FRAMES    (60),
        .GAMEOVER_FRAMES (180),
        .START_LIVES     (3)
    ) dut (
        .Clk               (Clk),
        .Reset_n           (Reset_n),
        .frame_tick        (frame_tick),
        .start_btn         (start_btn),
        .pipe_enter        (pipe_enter),
        .pipe_exit         (pipe_exit),
        .flag_reached      (flag_reached),
        .mario_dead        (mario_dead),
        .Level_Sel         (Level_Sel),
        .load_pulse        (load_pulse),
        .from_pipe         (from_pipe),
        .transition_active (transition_active),
        .freeze            (freeze),
        .lives             (lives)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (load_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_events();
        start_btn = 1'b0; pipe_enter = 1'b0; pipe_exit = 1'b0;
        flag_reached = 1'b0; mario_dead = 1'b0;
    endtask

    // One-cycle event pulse followed by two quiet cycles.
    task automatic pulse_event(input bit d, input bit f, input bit pe, input bit px, input bit sb);
        mario_dead = d; flag_reached = f; pipe_enter = pe; pipe_exit = px; start_btn = sb;
        step();
        clear_events();
        step();
        step();
    endtask

    // n frame ticks with random gaps; optional random event noise on tick cycles.
    task automatic run_ticks(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 1)) step();
            frame_tick = 1'b1;
            if (noise) begin
                mario_dead   = 1'($urandom_range(0, 1));
                flag_reached = 1'($urandom_range(0, 1));
                pipe_enter   = 1'($urandom_range(0, 1));
                pipe_exit    = 1'($urandom_range(0, 1));
                start_btn    = 1'($urandom_range(0, 1));
            end
            step();
            frame_tick = 1'b0;
            clear_events();
            step();
        end
    endtask

    // Bounded wait for load_pulse; ok=0 when the bound expires.
    task automatic await_load(output bit ok);
        int n = 0;
        while (load_pulse !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        ok = (load_pulse === 1'b1);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; frame_tick = 1'b0; clear_events();
        step(); step();
        checks++; if (Level_Sel !== 10'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", Level_Sel); end
        checks++; if (load_pulse !== 1'b0) begin errors++; $display("FAIL reset_load got=%b exp=0", load_pulse); end
        checks++; if (from_pipe !== 1'b0) begin errors++; $display("FAIL reset_from_pipe got=%b exp=0", from_pipe); end
        checks++; if (transition_active !== 1'b0) begin errors++; $display("FAIL reset_trans got=%b exp=0", transition_active); end
        checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL reset_freeze got=%b exp=1", freeze); end
        checks++; if (lives !== 3'd3) begin errors++; $display("FAIL reset_lives got=%0d exp=3", lives); end
        Reset_n = 1'b1;
        step(); step();
        checks++; if (freeze !== 1'b1 || transition_active !== 1'b0) begin errors++; $display("FAIL reset_title got freeze=%b trans=%b exp freeze=1 trans=0", freeze, transition_active); end
        m_room = 0; m_lives = 3; m_title = 1'b1;
    endtask

    task automatic test_start();
        bit ok;
        int base;
        pulse_event(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (transition_active !== 1'b1 || freeze !== 1'b1) begin errors++; $display("FAIL start_trans got trans=%b freeze=%b exp 1/1", transition_active, freeze); end
        base = pulse_cnt;
        run_ticks(59, 1'b0);
        repeat (3) step();
        checks++; if (Level_Sel !== 10'd0 || pulse_cnt !== base) begin errors++; $display("FAIL start_early got level=%0d pulses=%0d exp level=0 pulses=%0d", Level_Sel, pulse_cnt, base); end
        run_ticks(1, 1'b0);
        await_load(ok);
        checks++; if (!ok) begin errors++; $display("FAIL start_load got=no pulse exp=pulse"); end
        step(); step();
        checks++; if (Level_Sel !== 10'd1) begin errors++; $display("FAIL start_level got=%0d exp=1", Level_Sel); end
        checks++; if (pulse_cnt !== base + 1) begin errors++; $display("FAIL start_pulses got=%0d exp=%0d", pulse_cnt - base, 1); end
        checks++; if (freeze !== 1'b0 || lives !== 3'd3 || from_pipe !== 1'b0) begin errors++; $display("FAIL start_state got freeze=%b lives=%0d pipe=%b exp 0/3/0", freeze, lives, from_pipe); end
        m_room = 1; m_title = 1'b0;
    endtask

    task automatic test_pipes();
        bit ok;
        pulse_event(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_ticks(60, 1'b0);
        await_load(ok);
        step();
        checks++; if (!ok || Level_Sel !== 10'd2 || from_pipe !== 1'b1) begin errors++; $display("FAIL pipe_enter got ok=%b level=%0d pipe=%b exp 1/2/1", ok, Level_Sel, from_pipe); end
        // pipe_enter is not a room-2 event
        pulse_event(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (freeze !== 1'b0 || transition_active !== 1'b0) begin errors++; $display("FAIL pipe_ignored got freeze=%b trans=%b exp 0/0", freeze, transition_active); end
        pulse_event(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_ticks(60, 1'b0);
        await_load(ok);
        step();
        checks++; if (!ok || Level_Sel !== 10'd1 || from_pipe !== 1'b1) begin errors++; $display("FAIL pipe_exit got ok=%b level=%0d pipe=%b exp 1/1/1", ok, Level_Sel, from_pipe); end
        m_room = 1;
    endtask

    task automatic test_death_priority();
        bit ok;
        pulse_event(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (lives !== 3'd2) begin errors++; $display("FAIL death_lives got=%0d exp=2", lives); end
        run_ticks(60, 1'b0);
        await_load(ok);
        step();
        checks++; if (!ok || Level_Sel !== 10'd1 || from_pipe !== 1'b0) begin errors++; $display("FAIL death_room got ok=%b level=%0d pipe=%b exp 1/1/0", ok, Level_Sel, from_pipe); end
        m_lives = 2;
    endtask

    task automatic test_gameover();
        bit ok;
        int base;
        pulse_event(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_ticks(60, 1'b0);
        await_load(ok);
        step();
        checks++; if (!ok || lives !== 3'd1) begin errors++; $display("FAIL over_second got ok=%b lives=%0d exp 1/1", ok, lives); end
        pulse_event(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (lives !== 3'd0 || transition_active !== 1'b1 || freeze !== 1'b1) begin errors++; $display("FAIL over_enter got lives=%0d trans=%b freeze=%b exp 0/1/1", lives, transition_active, freeze); end
        base = pulse_cnt;
        run_ticks(179, 1'b0);
        repeat (3) step();
        checks++; if (Level_Sel !== 10'd1 || pulse_cnt !== base) begin errors++; $display("FAIL over_hold got level=%0d pulses=%0d exp level=1 pulses=%0d", Level_Sel, pulse_cnt, base); end
        run_ticks(1, 1'b0);
        await_load(ok);
        step();
        checks++; if (!ok || Level_Sel !== 10'd0 || lives !== 3'd3) begin errors++; $display("FAIL over_exit got ok=%b level=%0d lives=%0d exp 1/0/3", ok, Level_Sel, lives); end
        checks++; if (freeze !== 1'b1 || transition_active !== 1'b0) begin errors++; $display("FAIL over_title got freeze=%b trans=%b exp 1/0", freeze, transition_active); end
        m_room = 0; m_lives = 3; m_title = 1'b1;
    endtask

    task automatic test_reset_mid_transition();
        bit ok;
        int base;
        pulse_event(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_ticks(30, 1'b0);
        #2 Reset_n = 1'b0;
        #1;
        checks++; if (Level_Sel !== 10'd0 || transition_active !== 1'b0 || freeze !== 1'b1) begin errors++; $display("FAIL rst_async got level=%0d trans=%b freeze=%b exp 0/0/1", Level_Sel, transition_active, freeze); end
        step(); step();
        Reset_n = 1'b1;
        base = pulse_cnt;
        run_ticks(40, 1'b0);
        repeat (3) step();
        checks++; if (Level_Sel !== 10'd0 || pulse_cnt !== base) begin errors++; $display("FAIL rst_discard got level=%0d pulses=%0d exp level=0 pulses=%0d", Level_Sel, pulse_cnt, base); end
        checks++; if (freeze !== 1'b1 || transition_active !== 1'b0) begin errors++; $display("FAIL rst_title got freeze=%b trans=%b exp 1/0", freeze, transition_active); end
        pulse_event(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_ticks(60, 1'b0);
        await_load(ok);
        step();
        checks++; if (!ok || Level_Sel !== 10'd1) begin errors++; $display("FAIL rst_restart got ok=%b level=%0d exp 1/1", ok, Level_Sel); end
        m_room = 1; m_lives = 3; m_title = 1'b0;
    endtask

    task automatic test_ignored_and_win();
        bit ok;
        // lose a life first so the win visibly restores lives
        pulse_event(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_ticks(60, 1'b1);
        await_load(ok);
        step();
        checks++; if (!ok || lives !== 3'd2 || Level_Sel !== 10'd1) begin errors++; $display("FAIL win_death got ok=%b lives=%0d level=%0d exp 1/2/1", ok, lives, Level_Sel); end
        pulse_event(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_ticks(20, 1'b0);
        pulse_event(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        run_ticks(40, 1'b1);
        await_load(ok);
        step();
        checks++; if (!ok || Level_Sel !== 10'd3 || lives !== 3'd2 || from_pipe !== 1'b0) begin errors++; $display("FAIL win_castle got ok=%b level=%0d lives=%0d pipe=%b exp 1/3/2/0", ok, Level_Sel, lives, from_pipe); end
        pulse_event(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (freeze !== 1'b0 || Level_Sel !== 10'd3) begin errors++; $display("FAIL win_castle_ignore got freeze=%b level=%0d exp 0/3", freeze, Level_Sel); end
        pulse_event(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_ticks(60, 1'b0);
        await_load(ok);
        step();
        checks++; if (!ok || Level_Sel !== 10'd0 || lives !== 3'd3 || freeze !== 1'b1) begin errors++; $display("FAIL win_title got ok=%b level=%0d lives=%0d freeze=%b exp 1/0/3/1", ok, Level_Sel, lives, freeze); end
        m_room = 0; m_lives = 3; m_title = 1'b1;
    endtask

    // Game rules: returns whether an event is taken, whether it ends the game,
    // and the destination room / pipe flag.
    task automatic model_event(input bit d, input bit f, input bit pe, input bit px,
                               output bit acc, output bit over, output int nroom, output bit npipe);
        acc = 1'b1; over = 1'b0; nroom = m_room; npipe = 1'b0;
        if (d) begin
            if (m_lives > 1) nroom = 1;
            else begin over = 1'b1; nroom = 0; end
        end else if (f && m_room == 1) nroom = 3;
        else if (f && m_room == 3) nroom = 0;
        else if (pe && m_room == 1) begin nroom = 2; npipe = 1'b1; end
        else if (px && m_room == 2) begin nroom = 1; npipe = 1'b1; end
        else acc = 1'b0;
    endtask

    task automatic test_random();
        bit ok, acc, over, npipe, d, f, pe, px;
        int nroom, r;
        for (int it = 0; it < 24; it++) begin
            if (m_title) begin
                pulse_event(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                run_ticks(60, 1'b1);
                await_load(ok);
                step();
                checks++; if (!ok || Level_Sel !== 10'd1 || from_pipe !== 1'b0 || freeze !== 1'b0 || lives !== 3'(m_lives)) begin errors++; $display("FAIL rnd_start it=%0d got ok=%b level=%0d pipe=%b freeze=%b lives=%0d exp 1/1/0/0/%0d", it, ok, Level_Sel, from_pipe, freeze, lives, m_lives); end
                m_room = 1; m_title = 1'b0;
            end else begin
                r = $urandom_range(0, 9);
                d = (r == 0); f = (r >= 1 && r <= 3); pe = (r == 4 || r == 5); px = (r == 6 || r == 7);
                if (r >= 8) begin
                    f = 1'($urandom_range(0, 1)); pe = 1'($urandom_range(0, 1)); px = 1'($urandom_range(0, 1));
                end
                model_event(d, f, pe, px, acc, over, nroom, npipe);
                pulse_event(d, f, pe, px, 1'b0);
                if (!acc) begin
                    checks++; if (freeze !== 1'b0 || Level_Sel !== 10'(m_room)) begin errors++; $display("FAIL rnd_ignore it=%0d got freeze=%b level=%0d exp 0/%0d", it, freeze, Level_Sel, m_room); end
                end else if (over) begin
                    checks++; if (lives !== 3'd0 || transition_active !== 1'b1) begin errors++; $display("FAIL rnd_over it=%0d got lives=%0d trans=%b exp 0/1", it, lives, transition_active); end
                    run_ticks(179, 1'b1);
                    checks++; if (Level_Sel !== 10'(m_room)) begin errors++; $display("FAIL rnd_over_hold it=%0d got=%0d exp=%0d", it, Level_Sel, m_room); end
                    run_ticks(1, 1'b1);
                    await_load(ok);
                    step();
                    checks++; if (!ok || Level_Sel !== 10'd0 || lives !== 3'd3 || freeze !== 1'b1) begin errors++; $display("FAIL rnd_over_exit it=%0d got ok=%b level=%0d lives=%0d freeze=%b exp 1/0/3/1", it, ok, Level_Sel, lives, freeze); end
                    m_room = 0; m_lives = 3; m_title = 1'b1;
                end else begin
                    if (d) m_lives = m_lives - 1;
                    checks++; if (lives !== 3'(m_lives) || transition_active !== 1'b1) begin errors++; $display("FAIL rnd_accept it=%0d got lives=%0d trans=%b exp %0d/1", it, lives, transition_active, m_lives); end
                    run_ticks(60, 1'b1);
                    await_load(ok);
                    step();
                    if (nroom == 0) begin m_lives = 3; m_title = 1'b1; end
                    m_room = nroom;
                    checks++; if (!ok || Level_Sel !== 10'(m_room) || from_pipe !== npipe || lives !== 3'(m_lives) || freeze !== (nroom == 0)) begin errors++; $display("FAIL rnd_arrive it=%0d got ok=%b level=%0d pipe=%b lives=%0d freeze=%b exp 1/%0d/%b/%0d/%b", it, ok, Level_Sel, from_pipe, lives, freeze, m_room, npipe, m_lives, (nroom == 0)); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_pipes();
        test_death_priority();
        test_gameover();
        test_reset_mid_transition();
        test_ignored_and_win();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
